// File: rtl/alu_writeback.sv
// Writeback stage: commits ALU results to a single-port register file and holds the architectural flags.
// Latency: 1 cycle from the accept edge to rf_we; a MUL adds a second write one cycle later.
// Backpressure: in_ready drops only while the low word of a MUL is being written (one bubble per MUL).
module alu_writeback #(
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 4,
  parameter logic [3:0]  MUL_SEL = 4'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_sel,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wb_en,
  input  logic [DATA_W-1:0] in_out0,
  input  logic [DATA_W-1:0] in_out1,
  input  logic              in_cflag,
  input  logic              in_zflag,
  input  logic              in_vflag,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_v,
  output logic [15:0]       wb_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
  localparam logic [1:0] WR_HI = 2'd2;

  logic [1:0]        r_state;
  logic              r_is_mul;   // op held in WR_LO needs a high-word write
  logic [DATA_W-1:0] r_hi_data;  // in_out1 captured at accept
  logic [ADDR_W-1:0] r_hi_addr;  // rd+1, wraps within the register file
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_flag_c;
  logic              r_flag_z;
  logic              r_flag_v;
  logic [15:0]       r_wb_count;

  logic w_accept;
  logic w_busy_mul;

  // Stall upstream only while the MUL low word occupies the write port.
  always_comb begin
    w_busy_mul = (r_state == WR_LO) && r_is_mul;
    in_ready   = ~w_busy_mul;
    w_accept   = in_valid & ~w_busy_mul;
  end

  // Writeback FSM: a new accept always wins; otherwise drain a pending MUL high word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_is_mul   <= 1'b0;
      r_hi_data  <= '0;
      r_hi_addr  <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_accept) begin
      if (in_wb_en) begin
        r_state    <= WR_LO;
        r_is_mul   <= (in_sel == MUL_SEL);
        r_hi_data  <= in_out1;
        r_hi_addr  <= in_dest + ADDR_W'(1);
        r_rf_we    <= 1'b1;
        r_rf_waddr <= in_dest;
        r_rf_wdata <= in_out0;
      end else begin
        // Flags-only op: address/data keep their last values.
        r_state  <= IDLE;
        r_is_mul <= 1'b0;
        r_rf_we  <= 1'b0;
      end
    end else begin
      case (r_state)
        WR_LO: begin
          if (r_is_mul) begin
            r_state    <= WR_HI;
            r_is_mul   <= 1'b0;
            r_rf_we    <= 1'b1;
            r_rf_waddr <= r_hi_addr;
            r_rf_wdata <= r_hi_data;
          end else begin
            r_state <= IDLE;
            r_rf_we <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_is_mul <= 1'b0;
          r_rf_we  <= 1'b0;
        end
      endcase
    end
  end

  // Architectural flags load on every accept, regardless of wb_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_accept) begin
      r_flag_c <= in_cflag;
      r_flag_z <= in_zflag;
      r_flag_v <= in_vflag;
    end
  end

  // Count every cycle in which the write port is active; wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_count <= '0;
    end else if (r_rf_we) begin
      r_wb_count <= r_wb_count + 16'd1;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign flag_c   = r_flag_c;
  assign flag_z   = r_flag_z;
  assign flag_v   = r_flag_v;
  assign wb_count = r_wb_count;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: vector table plus hand sequences, writes checked against a scoreboard queue.
// Expected writes are queued when an op is driven and popped when rf_we is seen.
// All waits on the DUT are bounded.
module tb_alu_writeback;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_sel;
  logic [ADDR_W-1:0] in_dest;
  logic              in_wb_en;
  logic [DATA_W-1:0] in_out0;
  logic [DATA_W-1:0] in_out1;
  logic              in_cflag, in_zflag, in_vflag;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              flag_c, flag_z, flag_v;
  logic [15:0]       wb_count;

  alu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MUL_SEL(4'd2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_dest(in_dest), .in_wb_en(in_wb_en),
    .in_out0(in_out0), .in_out1(in_out1),
    .in_cflag(in_cflag), .in_zflag(in_zflag), .in_vflag(in_vflag),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v),
    .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        sel;
    logic [ADDR_W-1:0] dest;
    logic              wb_en;
    logic [DATA_W-1:0] out0;
    logic [DATA_W-1:0] out1;
    logic              c, z, v;
    int                nwr;    // expected register-file writes
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         sb_q[$];
  bit          sb_en;
  int          checks;
  int          errors;
  logic [15:0] exp_cnt;
  vec_t        vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one op (at posedge+1), queue its expected writes, return at posedge+1 after the accept.
  task automatic send(input vec_t v);
    wr_t w;
    int  wait_cyc;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 10) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
    end
    in_valid = 1'b1; in_sel = v.sel; in_dest = v.dest; in_wb_en = v.wb_en;
    in_out0 = v.out0; in_out1 = v.out1;
    in_cflag = v.c; in_zflag = v.z; in_vflag = v.v;
    if (v.wb_en) begin
      w.addr = v.dest; w.data = v.out0;
      sb_q.push_back(w);
      exp_cnt = exp_cnt + 16'd1;
      if (v.sel == 4'd2) begin
        w.addr = v.dest + ADDR_W'(1); w.data = v.out1;
        sb_q.push_back(w);
        exp_cnt = exp_cnt + 16'd1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_out0 = 16'hDEAD; in_out1 = 16'hBEEF;  // prove high word is not resampled
  endtask

  function automatic vec_t mk(input logic [3:0] sel, input logic [3:0] dest, input logic wb,
                              input logic [15:0] o0, input logic [15:0] o1,
                              input logic c, input logic z, input logic v, input int n);
    vec_t r;
    r.sel = sel; r.dest = dest; r.wb_en = wb; r.out0 = o0; r.out1 = o1;
    r.c = c; r.z = z; r.v = v; r.nwr = n;
    return r;
  endfunction

  initial begin
    vec_t v;
    logic [15:0] base;
    checks = 0; errors = 0; exp_cnt = 16'd0; sb_en = 1'b1;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 4'd0; in_dest = '0; in_wb_en = 1'b0;
    in_out0 = '0; in_out1 = '0; in_cflag = 1'b0; in_zflag = 1'b0; in_vflag = 1'b0;

    vt[0] = mk(4'd0, 4'd3,  1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1); // ADD
    vt[1] = mk(4'd2, 4'd15, 1'b1, 16'h5678, 16'h0012, 1'b0, 1'b0, 1'b1, 2); // MUL, rd wraps
    vt[2] = mk(4'd5, 4'd7,  1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 0); // CMP flags only
    vt[3] = mk(4'd2, 4'd7,  1'b0, 16'h1111, 16'h2222, 1'b1, 1'b1, 1'b1, 0); // MUL, no wb
    vt[4] = mk(4'd1, 4'd0,  1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1); // SUB
    vt[5] = mk(4'd2, 4'd6,  1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, 2); // MUL

    // Scoreboard monitor: every write-port cycle must match the head of the queue.
    fork
      forever begin
        wr_t w;
        @(negedge clk);
        if (rst_n && rf_we && sb_en) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected_write addr=%0h data=%0h expected=none", rf_waddr, rf_wdata);
          end else begin
            w = sb_q.pop_front();
            check("sb_waddr", 32'(rf_waddr), 32'(w.addr));
            check("sb_wdata", 32'(rf_wdata), 32'(w.data));
          end
        end
      end
    join_none

    // Reset state, sampled while reset is asserted.
    #12;
    check("rst_we",    32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", 32'(rf_wdata), 32'd0);
    check("rst_flags", 32'({flag_c, flag_z, flag_v}), 32'd0);
    check("rst_count", 32'(wb_count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: one op each, then drain and check flags, count and scoreboard.
    for (int i = 0; i < 6; i++) begin
      v = vt[i];
      base = wb_count;
      send(v);
      @(negedge clk);
      check("vec_we_after_1", 32'(rf_we), 32'(v.wb_en));
      check("vec_flags", 32'({flag_c, flag_z, flag_v}), 32'({v.c, v.z, v.v}));
      repeat (2) @(negedge clk);
      check("vec_we_idle", 32'(rf_we), 32'd0);
      check("vec_count", 32'(wb_count), 32'(exp_cnt));
      check("vec_count_delta", 32'(wb_count - base), 32'(v.nwr));
      check("vec_sb_empty", 32'(sb_q.size()), 32'd0);
    end

    // MUL timing: low word with in_ready low, then high word to rd+1 (15 -> 0).
    send(vt[1]);
    @(negedge clk);
    check("mul_lo_ready", 32'(in_ready), 32'd0);
    check("mul_lo_waddr", 32'(rf_waddr), 32'hF);
    check("mul_lo_wdata", 32'(rf_wdata), 32'h5678);
    @(negedge clk);
    check("mul_hi_we",    32'(rf_we), 32'd1);
    check("mul_hi_waddr", 32'(rf_waddr), 32'h0);
    check("mul_hi_wdata", 32'(rf_wdata), 32'h0012);
    check("mul_hi_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);

    // Back-to-back single-word ops rd=1..4: no bubbles.
    base = wb_count;
    for (int i = 1; i <= 4; i++) begin
      check("b2b_ready", 32'(in_ready), 32'd1);
      send(mk(4'd0, 4'(i), 1'b1, 16'(16'h0100 + i), 16'h0, 1'b0, 1'b0, 1'b0, 1));
    end
    @(negedge clk);
    check("b2b_we_last", 32'(rf_we), 32'd1);
    check("b2b_count_mid", 32'(wb_count - base), 32'd3);
    @(negedge clk);
    check("b2b_we_done", 32'(rf_we), 32'd0);
    check("b2b_count", 32'(wb_count - base), 32'd4);

    // MUL followed immediately by ADD: one bubble, writes stay ordered.
    send(vt[5]);
    send(mk(4'd0, 4'd9, 1'b1, 16'h0BAD, 16'h0, 1'b0, 1'b1, 1'b0, 1));
    repeat (3) @(negedge clk);
    check("mul_add_count", 32'(wb_count), 32'(exp_cnt));
    check("mul_add_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset during the MUL low-word cycle: high word must never appear.
    send(mk(4'd2, 4'd9, 1'b1, 16'h1357, 16'h2468, 1'b1, 1'b0, 1'b1, 2));
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    check("mrst_we",    32'(rf_we), 32'd0);
    check("mrst_waddr", 32'(rf_waddr), 32'd0);
    check("mrst_wdata", 32'(rf_wdata), 32'd0);
    check("mrst_flags", 32'({flag_c, flag_z, flag_v}), 32'd0);
    check("mrst_count", 32'(wb_count), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);
    check("mrst_lo_seen", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    exp_cnt = 16'd0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mrst_no_hi", 32'(rf_we), 32'd0);
      check("mrst_ready_after", 32'(in_ready), 32'd1);
    end

    // Counter wrap: 65535 streamed writes, then one more rolls to zero.
    @(posedge clk); #1;
    sb_en = 1'b0;
    in_valid = 1'b1; in_sel = 4'd0; in_dest = 4'd1; in_wb_en = 1'b1; in_out0 = 16'h0;
    repeat (65535) @(posedge clk);
    #1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("wrap_pre", 32'(wb_count), 32'hFFFF);
    exp_cnt = 16'hFFFF;
    sb_en = 1'b1;
    @(posedge clk); #1;
    send(mk(4'd0, 4'd5, 1'b1, 16'hC0DE, 16'h0, 1'b0, 1'b0, 1'b0, 1));
    repeat (3) @(negedge clk);
    check("wrap_zero", 32'(wb_count), 32'(exp_cnt));
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
